// File: rtl/csrs_machine_bank.sv
// rtl/csrs_machine_bank.sv - RV32 machine-mode CSR bank; counters built only with CSRS_MACHINE_COUNTERS_EN
module csrs_machine_bank #(
    parameter logic [31:0] HART_ID    = 32'h0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter logic [31:0] MTVEC_INIT = 32'h0,
    parameter logic [31:0] MEPC_INIT  = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RDEN,
    input  logic [11:0] RADDR,
    output logic        RVALID,
    output logic [31:0] RDATA,
    output logic        RERR,
    input  logic        WREN,
    input  logic [11:0] WADDR,
    input  logic [31:0] WDATA,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_CAUSE,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_TVAL,
    input  logic        MRET_EN,
    input  logic        RETIRE,
    input  logic [2:0]  IRQ_IN,
    output logic [31:0] TRAP_VECTOR,
    output logic [31:0] MEPC_OUT,
    output logic        IRQ_PENDING
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        st_mie;
    logic        st_mpie;
    logic [2:0]  ie;        // {MEIE, MTIE, MSIE}
    logic [2:0]  ip;        // {MEIP, MTIP, MSIP}
    logic [29:0] tvec_base;
    logic [1:0]  tvec_mode;
    logic [31:0] mscratch;
    logic [31:0] mtval;
    logic [31:0] mcause;
    logic [29:0] mepc_word;
    logic [31:0] rd_val;
    logic        rd_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            ie          <= 3'b000;
            ip          <= 3'b000;
            tvec_base   <= MTVEC_INIT[31:2];
            tvec_mode   <= MTVEC_INIT[1:0];
            mscratch    <= 32'h0;
            mtval       <= 32'h0;
            mcause      <= 32'h0;
            mepc_word   <= MEPC_INIT[31:2];
            IRQ_PENDING <= 1'b0;
            RVALID      <= 1'b0;
            RDATA       <= 32'h0;
            RERR        <= 1'b0;
        end else begin
            ip          <= IRQ_IN;
            IRQ_PENDING <= st_mie & |(ip & ie);
            RVALID      <= RDEN;
            RDATA       <= RDEN ? rd_val : 32'h0;
            RERR        <= RDEN & ~rd_hit;

            if (TRAP_EN) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (MRET_EN) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (WREN && WADDR == A_MSTATUS) begin
                st_mie  <= WDATA[3];
                st_mpie <= WDATA[7];
            end

            if (TRAP_EN) begin
                mepc_word <= TRAP_PC[31:2];
                mcause    <= TRAP_CAUSE;
                mtval     <= TRAP_TVAL;
            end else if (WREN) begin
                case (WADDR)
                    A_MEPC:   mepc_word <= WDATA[31:2];
                    A_MCAUSE: mcause    <= WDATA;
                    A_MTVAL:  mtval     <= WDATA;
                    default:  ;
                endcase
            end

            if (WREN) begin
                case (WADDR)
                    A_MIE:      ie       <= {WDATA[11], WDATA[7], WDATA[3]};
                    A_MSCRATCH: mscratch <= WDATA;
                    A_MTVEC: begin
                        tvec_base <= WDATA[31:2];
                        // reserved modes 2/3 leave the previous mode in place
                        if (!WDATA[1]) tvec_mode <= WDATA[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CSRS_MACHINE_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcycle   <= 64'h0;
            minstret <= 64'h0;
        end else begin
            if (WREN && WADDR == A_MCYCLE)        mcycle[31:0]  <= WDATA;
            else if (WREN && WADDR == A_MCYCLEH)  mcycle[63:32] <= WDATA;
            else                                  mcycle        <= mcycle + 64'd1;

            if (WREN && WADDR == A_MINSTRET)       minstret[31:0]  <= WDATA;
            else if (WREN && WADDR == A_MINSTRETH) minstret[63:32] <= WDATA;
            else if (RETIRE)                       minstret        <= minstret + 64'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = RETIRE;
`endif

    always_comb begin
        rd_val = 32'h0;
        rd_hit = 1'b1;
        case (RADDR)
            A_MSTATUS:  rd_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            A_MISA:     rd_val = MISA_VALUE;
            A_MIE:      rd_val = {20'b0, ie[2], 3'b0, ie[1], 3'b0, ie[0], 3'b0};
            A_MTVEC:    rd_val = {tvec_base, tvec_mode};
            A_MSCRATCH: rd_val = mscratch;
            A_MEPC:     rd_val = {mepc_word, 2'b00};
            A_MCAUSE:   rd_val = mcause;
            A_MTVAL:    rd_val = mtval;
            A_MIP:      rd_val = {20'b0, ip[2], 3'b0, ip[1], 3'b0, ip[0], 3'b0};
`ifdef CSRS_MACHINE_COUNTERS_EN
            A_MCYCLE:    rd_val = mcycle[31:0];
            A_MCYCLEH:   rd_val = mcycle[63:32];
            A_MINSTRET:  rd_val = minstret[31:0];
            A_MINSTRETH: rd_val = minstret[63:32];
`else
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: rd_val = 32'h0;
`endif
            A_MVENDORID, A_MARCHID, A_MIMPID: rd_val = 32'h0;
            A_MHARTID:  rd_val = HART_ID;
            default:    rd_hit = 1'b0;
        endcase
    end

    // vectored mode only redirects interrupts; exceptions always go to the base
    assign TRAP_VECTOR = (tvec_mode == 2'd1 && TRAP_CAUSE[31])
                       ? {tvec_base, 2'b00} + {25'b0, TRAP_CAUSE[4:0], 2'b00}
                       : {tvec_base, 2'b00};
    assign MEPC_OUT    = {mepc_word, 2'b00};

endmodule

// File: tb/tb_csrs_machine_bank.sv
// tb/tb_csrs_machine_bank.sv - table, directed and random checks of csrs_machine_bank against a CSR model
module tb_csrs_machine_bank;

    localparam logic [31:0] P_HART  = 32'h5;
    localparam logic [31:0] P_MISA  = 32'h4000_0100;
    localparam logic [31:0] P_MTVEC = 32'h0000_4000;
    localparam logic [31:0] P_MEPC  = 32'h0000_0103;

    logic        CLK = 1'b0;
    logic        RST, RDEN, WREN, TRAP_EN, MRET_EN, RETIRE;
    logic [11:0] RADDR, WADDR;
    logic [31:0] WDATA, TRAP_CAUSE, TRAP_PC, TRAP_TVAL;
    logic [2:0]  IRQ_IN;
    logic        RVALID, RERR, IRQ_PENDING;
    logic [31:0] RDATA, TRAP_VECTOR, MEPC_OUT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    csrs_machine_bank #(
        .HART_ID(P_HART), .MISA_VALUE(P_MISA), .MTVEC_INIT(P_MTVEC), .MEPC_INIT(P_MEPC)
    ) dut (
        .CLK(CLK), .RST(RST), .RDEN(RDEN), .RADDR(RADDR), .RVALID(RVALID), .RDATA(RDATA),
        .RERR(RERR), .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA), .TRAP_EN(TRAP_EN),
        .TRAP_CAUSE(TRAP_CAUSE), .TRAP_PC(TRAP_PC), .TRAP_TVAL(TRAP_TVAL), .MRET_EN(MRET_EN),
        .RETIRE(RETIRE), .IRQ_IN(IRQ_IN), .TRAP_VECTOR(TRAP_VECTOR), .MEPC_OUT(MEPC_OUT),
        .IRQ_PENDING(IRQ_PENDING)
    );

    // architectural view of each CSR as a full 32-bit value
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_scr, m_epc, m_cause, m_tval, m_mip;
    logic [63:0] m_cycle, m_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = P_MTVEC; m_scr = 0;
        m_epc = P_MEPC & ~32'h3; m_cause = 0; m_tval = 0; m_mip = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    function automatic logic [32:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b0, m_mstatus | 32'h1800};
            12'h301: return {1'b0, P_MISA};
            12'h304: return {1'b0, m_mie};
            12'h305: return {1'b0, m_mtvec};
            12'h340: return {1'b0, m_scr};
            12'h341: return {1'b0, m_epc};
            12'h342: return {1'b0, m_cause};
            12'h343: return {1'b0, m_tval};
            12'h344: return {1'b0, m_mip};
            12'hB00: return {1'b0, m_cycle[31:0]};
            12'hB80: return {1'b0, m_cycle[63:32]};
            12'hB02: return {1'b0, m_instret[31:0]};
            12'hB82: return {1'b0, m_instret[63:32]};
            12'hF11, 12'hF12, 12'hF13: return {1'b0, 32'h0};
            12'hF14: return {1'b0, P_HART};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // one clock: check combinational vector, advance model, compare registered outputs
    task automatic step();
        logic [31:0] n_ms, n_ie, n_tv, n_scr, n_epc, n_cause, n_tval, n_ip, base, e_vec, e_data;
        logic [63:0] n_cyc, n_ins;
        logic [32:0] rd;
        logic        n_pend, e_valid, e_err;
        #1;
        base  = m_mtvec & ~32'h3;
        e_vec = (m_mtvec[1:0] == 2'd1 && TRAP_CAUSE[31]) ? base + 32'(TRAP_CAUSE[4:0]) * 4 : base;
        chk("trap_vector", TRAP_VECTOR, e_vec);
        n_ms = m_mstatus; n_ie = m_mie; n_tv = m_mtvec; n_scr = m_scr; n_epc = m_epc;
        n_cause = m_cause; n_tval = m_tval; n_cyc = m_cycle; n_ins = m_instret;
`ifdef CSRS_MACHINE_COUNTERS_EN
        n_cyc = m_cycle + 1;
        if (RETIRE) n_ins = m_instret + 1;
`endif
        if (WREN) begin
            case (WADDR)
                12'h300: n_ms = WDATA & 32'h88;
                12'h304: n_ie = WDATA & 32'h888;
                12'h305: n_tv = (WDATA[1:0] >= 2'd2) ? ((WDATA & ~32'h3) | (m_mtvec & 32'h3)) : WDATA;
                12'h340: n_scr = WDATA;
                12'h341: n_epc = WDATA & ~32'h3;
                12'h342: n_cause = WDATA;
                12'h343: n_tval = WDATA;
`ifdef CSRS_MACHINE_COUNTERS_EN
                12'hB00: n_cyc = {m_cycle[63:32], WDATA};
                12'hB80: n_cyc = {WDATA, m_cycle[31:0]};
                12'hB02: n_ins = {m_instret[63:32], WDATA};
                12'hB82: n_ins = {WDATA, m_instret[31:0]};
`endif
                default: ;
            endcase
        end
        if (MRET_EN) n_ms = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
        if (TRAP_EN) begin
            n_ms = m_mstatus[3] ? 32'h80 : 32'h0;
            n_epc = TRAP_PC & ~32'h3; n_cause = TRAP_CAUSE; n_tval = TRAP_TVAL;
        end
        n_ip = (IRQ_IN[2] ? 32'h800 : 0) | (IRQ_IN[1] ? 32'h80 : 0) | (IRQ_IN[0] ? 32'h8 : 0);
        n_pend = m_mstatus[3] && ((m_mip & m_mie) != 0);
        rd = model_read(RADDR);
        e_valid = RDEN; e_data = RDEN ? rd[31:0] : 32'h0; e_err = RDEN & rd[32];
        @(posedge CLK);
        #1;
        if (RST) begin
            model_reset();
            n_pend = 0; e_valid = 0; e_data = 0; e_err = 0;
        end else begin
            m_mstatus = n_ms; m_mie = n_ie; m_mtvec = n_tv; m_scr = n_scr; m_epc = n_epc;
            m_cause = n_cause; m_tval = n_tval; m_mip = n_ip; m_cycle = n_cyc; m_instret = n_ins;
        end
        chk("rvalid", RVALID, e_valid);
        chk("rdata", RDATA, e_data);
        chk("rerr", RERR, e_err);
        chk("irq_pending", IRQ_PENDING, n_pend);
        chk("mepc_out", MEPC_OUT, m_epc);
    endtask

    task automatic idle();
        RST = 0; RDEN = 0; WREN = 0; TRAP_EN = 0; MRET_EN = 0; RETIRE = 0;
    endtask

    typedef struct {
        logic        wren;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        rden;
        logic [11:0] raddr;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic [31:0] exp_rdata;
        logic        exp_rerr;
    } vec_t;

    vec_t tbl[$];
    logic [11:0] addrs[18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                               12'hF12, 12'hF13, 12'hF14, 12'h7C0};

    function automatic logic [11:0] pick();
        int k = $urandom_range(0, 19);
        return (k < 18) ? addrs[k] : 12'($urandom);
    endfunction

    initial begin
        logic [11:0] rst_addr[9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                     12'h343, 12'h344, 12'hB80};
        logic [31:0] rst_val[9]  = '{32'h1800, 32'h0, 32'h4000, 32'h0, 32'h100, 32'h0,
                                     32'h0, 32'h0, 32'h0};
        idle();
        RADDR = 0; WADDR = 0; WDATA = 0; TRAP_CAUSE = 0; TRAP_PC = 0; TRAP_TVAL = 32'h55; IRQ_IN = 0;
        RST = 1;
        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        chk("reset_rvalid", RVALID, 1'b0);
        chk("reset_rdata", RDATA, 32'h0);
        chk("reset_rerr", RERR, 1'b0);
        chk("reset_irq_pending", IRQ_PENDING, 1'b0);
        chk("reset_mepc_out", MEPC_OUT, 32'h100);
        chk("reset_trap_vector", TRAP_VECTOR, 32'h4000);
        RST = 0;

        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'hF14, 0, 32'h0,        32'h0,    0, 32'h5,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h7C0, 0, 32'h0,        32'h0,    0, 32'h0,        1});
        tbl.push_back('{1, 12'h300, 32'h8,        1, 12'h300, 0, 32'h0,        32'h0,    0, 32'h1800,     0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h300, 0, 32'h0,        32'h0,    0, 32'h1808,     0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h300, 1, 32'h8000_0007, 32'h1003, 0, 32'h1808,    0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h341, 0, 32'h0,        32'h0,    0, 32'h1000,     0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h342, 0, 32'h0,        32'h0,    0, 32'h8000_0007, 0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h300, 0, 32'h0,        32'h0,    0, 32'h1880,     0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h343, 0, 32'h0,        32'h0,    1, 32'h55,       0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h300, 0, 32'h0,        32'h0,    0, 32'h1888,     0});
        tbl.push_back('{1, 12'h305, 32'h2001,     1, 12'h305, 0, 32'h0,        32'h0,    0, 32'h4000,     0});
        tbl.push_back('{1, 12'h305, 32'h3002,     1, 12'h305, 0, 32'h0,        32'h0,    0, 32'h2001,     0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h305, 0, 32'h0,        32'h0,    0, 32'h3001,     0});
        tbl.push_back('{1, 12'h304, 32'hFFFF_FFFF, 1, 12'h344, 0, 32'h0,       32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h304, 0, 32'h0,        32'h0,    0, 32'h888,      0});
        tbl.push_back('{1, 12'h344, 32'hFFFF_FFFF, 1, 12'hF11, 0, 32'h0,       32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h344, 0, 32'h0,        32'h0,    0, 32'h0,        0});
        tbl.push_back('{1, 12'h301, 32'h0,        1, 12'h301, 0, 32'h0,        32'h0,    0, 32'h4000_0100, 0});
        tbl.push_back('{1, 12'h340, 32'hDEAD_BEEF, 1, 12'hF12, 0, 32'h0,       32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h340, 0, 32'h0,        32'h0,    0, 32'hDEAD_BEEF, 0});
        tbl.push_back('{1, 12'h341, 32'h1237,     1, 12'hF13, 0, 32'h0,        32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h341, 0, 32'h0,        32'h0,    0, 32'h1234,     0});
        tbl.push_back('{1, 12'hF14, 32'hFFFF_FFFF, 1, 12'hB80, 0, 32'h0,       32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'hF14, 0, 32'h0,        32'h0,    0, 32'h5,        0});
        tbl.push_back('{1, 12'h7C0, 32'h1,        1, 12'hB82, 0, 32'h0,        32'h0,    0, 32'h0,        0});
        tbl.push_back('{0, 12'h000, 32'h0,        1, 12'h7C0, 0, 32'h0,        32'h0,    0, 32'h0,        1});

        foreach (tbl[i]) begin
            idle();
            WREN = tbl[i].wren; WADDR = tbl[i].waddr; WDATA = tbl[i].wdata;
            RDEN = tbl[i].rden; RADDR = tbl[i].raddr; TRAP_EN = tbl[i].trap;
            TRAP_CAUSE = tbl[i].cause; TRAP_PC = tbl[i].pc; MRET_EN = tbl[i].mret;
            step();
            chk($sformatf("tbl%0d_rdata", i), RDATA, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_rerr", i), RERR, tbl[i].exp_rerr);
        end

        // vectored mtvec: interrupts offset by cause, exceptions use the base
        idle(); WREN = 1; WADDR = 12'h305; WDATA = 32'h2001; step();
        idle(); TRAP_CAUSE = 32'h8000_0003; #1;
        chk("tvec_vectored_irq", TRAP_VECTOR, 32'h200C);
        TRAP_CAUSE = 32'h0000_0003; #1;
        chk("tvec_vectored_exc", TRAP_VECTOR, 32'h2000);
        step();

`ifdef CSRS_MACHINE_COUNTERS_EN
        idle(); WREN = 1; WADDR = 12'hB00; WDATA = 32'hFFFF_FFFF; step();
        idle(); WREN = 1; WADDR = 12'hB80; WDATA = 32'h0; step();
        idle(); step();
        idle(); RDEN = 1; RADDR = 12'hB80; step();
        chk("mcycleh_carry", RDATA, 32'h1);
`else
        idle(); RDEN = 1; RADDR = 12'hB00; step();
        chk("mcycle_absent_rdata", RDATA, 32'h0);
        chk("mcycle_absent_rerr", RERR, 1'b0);
`endif

        idle(); WREN = 1; WADDR = 12'h304; WDATA = 32'h80; step();
        idle(); WREN = 1; WADDR = 12'h300; WDATA = 32'h8; step();
        idle(); IRQ_IN = 3'b010; step();
        chk("irq_lag_one", IRQ_PENDING, 1'b0);
        idle(); step();
        chk("irq_lag_two", IRQ_PENDING, 1'b1);
        idle(); TRAP_EN = 1; TRAP_CAUSE = 32'h8000_0007; TRAP_PC = 32'h2000;
        WREN = 1; WADDR = 12'h300; WDATA = 32'h8; step();
        idle(); RDEN = 1; RADDR = 12'h300; step();
        chk("trap_over_write", RDATA, 32'h1880);
        chk("irq_after_trap", IRQ_PENDING, 1'b0);

        idle(); IRQ_IN = 3'b000; RST = 1; RDEN = 1; RADDR = 12'h340; step();
        chk("rst_drops_read", RVALID, 1'b0);
        for (int i = 0; i < 9; i++) begin
            idle(); RDEN = 1; RADDR = rst_addr[i]; step();
            chk($sformatf("rst_val_%h", rst_addr[i]), RDATA, rst_val[i]);
        end

        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 199) == 0);
            RDEN = $urandom_range(0, 1) == 1; RADDR = pick();
            WREN = $urandom_range(0, 1) == 1; WADDR = pick(); WDATA = $urandom;
            TRAP_EN = ($urandom_range(0, 9) == 0); TRAP_CAUSE = $urandom;
            TRAP_PC = $urandom; TRAP_TVAL = $urandom;
            MRET_EN = ($urandom_range(0, 9) == 0); RETIRE = $urandom_range(0, 1) == 1;
            IRQ_IN = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
